// File: rtl/pm_pkg.sv
// Shared types and defaults for the P-M cycle sequencer.
// Holds the state enum, default widths/lengths and the pulse-counter width helper.
package pm_pkg;

  typedef enum logic [1:0] {RUN, ARM, KC, PC} pm_seq_st_t;

  localparam int LG_W_DEF      = 3;
  localparam int LK_W_DEF      = 4;
  localparam int MC_W_DEF      = 2;
  localparam int KC_LEN_DEF    = 2;
  localparam int PC_LEN_DEF    = 1;
  localparam int TO_CYCLES_DEF = 1024;

  // The pulse counter runs 0..len-1, so it needs clog2(len) bits but never fewer than one.
  function automatic int pm_len_w(input int len);
    return (len <= 1) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/pm_sat_cnt.sv
// Generic up/down counter with clear, load and wrap/saturate select (SAT=1 saturates).
// Latency: one clock, the new value is visible on the cycle after the edge.
// Backpressure: none; clr > ld > inc/dec, and inc together with dec holds.
module pm_sat_cnt #(
  parameter int W   = 4,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (inc && !dec) begin
      if (!(SAT && q == ALL_ONES)) q <= q + W'(1);
    end else if (dec && !inc) begin
      if (!(SAT && q == '0)) q <= q - W'(1);
    end
  end

endmodule

// File: rtl/pm_seq.sv
// P-M cycle sequencer: RUN/ARM/KC/PC with counted kc/pc pulses, PR/PRZERW flags, LG/LK/MC counters.
// Latency: ekc->ARM 1 clk, got->kc 1 clk, kc KC_LEN clks then pc PC_LEN clks; counters update next cycle.
// Backpressure: none; ARM waits for got (bounded by TO_CYCLES when PM_CYC_TO_EN is defined).
module pm_seq
  import pm_pkg::*;
#(
  parameter int LG_W      = LG_W_DEF,
  parameter int LK_W      = LK_W_DEF,
  parameter int MC_W      = MC_W_DEF,
  parameter int KC_LEN    = KC_LEN_DEF,
  parameter int PC_LEN    = PC_LEN_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            clm,
  input  logic            ekc,
  input  logic            got,
  input  logic            fetch_req,
  input  logic            irq_req,
  output logic            kc,
  output logic            pc,
  output logic            pr,
  output logic            przerw,
  output logic            zerstan,
  input  logic            lg_ld,
  input  logic [LG_W-1:0] lg_d,
  input  logic            lg_inc,
  output logic [LG_W-1:0] lg,
  input  logic            lk_ld,
  input  logic [LK_W-1:0] lk_d,
  input  logic            lk_dec,
  output logic [LK_W-1:0] lk,
  output logic            lk_nz,
  input  logic            mc_inc,
  input  logic            mc_clr,
  output logic [MC_W-1:0] mc,
  output logic            mc_zero,
  output logic            mc_full,
  output logic            cyc_to
);

  localparam int LEN_W = pm_len_w((KC_LEN > PC_LEN) ? KC_LEN : PC_LEN);
  localparam logic [LEN_W-1:0] KC_LAST = LEN_W'(KC_LEN - 1);
  localparam logic [LEN_W-1:0] PC_LAST = LEN_W'(PC_LEN - 1);

  pm_seq_st_t       st_q, st_d;
  logic [LEN_W-1:0] len_q;
  logic             len_clr;
  logic             flag_latch;
  logic             to_hit;

  always_comb begin
    st_d       = st_q;
    len_clr    = 1'b1;
    flag_latch = 1'b0;
    case (st_q)
      RUN: if (ekc) st_d = ARM;
      ARM: if (got || to_hit) st_d = KC;
      KC: begin
        len_clr = 1'b0;
        if (len_q == KC_LAST) begin
          st_d       = PC;
          len_clr    = 1'b1;
          flag_latch = 1'b1;
        end
      end
      PC: begin
        len_clr = 1'b0;
        if (len_q == PC_LAST) begin
          st_d    = RUN;
          len_clr = 1'b1;
        end
      end
      default: st_d = RUN;
    endcase
  end

  // kc/pc come straight from flops so downstream sees glitch-free pulses.
  always_ff @(posedge clk) begin
    if (clm) begin
      st_q   <= RUN;
      len_q  <= '0;
      kc     <= 1'b0;
      pc     <= 1'b0;
      pr     <= 1'b1;
      przerw <= 1'b0;
    end else begin
      st_q  <= st_d;
      len_q <= len_clr ? '0 : len_q + LEN_W'(1);
      kc    <= (st_d == KC);
      pc    <= (st_d == PC);
      if (flag_latch) begin
        przerw <= irq_req;
        pr     <= !irq_req && fetch_req;
      end
    end
  end

`ifdef PM_CYC_TO_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] to_q;

  assign to_hit = (st_q == ARM) && !got && (to_q == TO_W'(TO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (clm) begin
      to_q   <= '0;
      cyc_to <= 1'b0;
    end else begin
      to_q <= (st_q == ARM) ? to_q + TO_W'(1) : '0;
      if (to_hit) cyc_to <= 1'b1;
    end
  end
`else
  localparam int unused_to_cycles = TO_CYCLES;
  assign to_hit = 1'b0;
  assign cyc_to = 1'b0;
`endif

  assign zerstan = pc | clm;
  assign lk_nz   = (lk != '0);
  assign mc_zero = (mc == '0);
  assign mc_full = (mc == {MC_W{1'b1}});

  pm_sat_cnt #(.W(LG_W), .SAT(1'b0)) u_lg (
    .clk(clk), .clr(zerstan), .ld(lg_ld), .d(lg_d),
    .inc(lg_inc), .dec(1'b0), .q(lg)
  );

  pm_sat_cnt #(.W(LK_W), .SAT(1'b1)) u_lk (
    .clk(clk), .clr(zerstan), .ld(lk_ld), .d(lk_d),
    .inc(1'b0), .dec(lk_dec), .q(lk)
  );

  // MC survives the pc strobe; only master clear or an explicit clear empties it.
  pm_sat_cnt #(.W(MC_W), .SAT(1'b1)) u_mc (
    .clk(clk), .clr(clm | mc_clr), .ld(1'b0), .d('0),
    .inc(mc_inc), .dec(1'b0), .q(mc)
  );

endmodule

// File: tb/tb_pm_seq.sv
// Bench for pm_seq: directed and random stimulus against a timeline-based reference model.
module tb_pm_seq;

  localparam int KC_LEN = 2;
  localparam int PC_LEN = 1;
  localparam int TO_CYC = 8;

  typedef struct packed {
    logic       clm, ekc, got, fetch, irq;
    logic       lg_ld;
    logic [2:0] lg_d;
    logic       lg_inc, lk_ld;
    logic [3:0] lk_d;
    logic       lk_dec, mc_inc, mc_clr;
  } stim_t;

  typedef struct packed {
    logic       kc, pc, pr, przerw, zerstan;
    logic [2:0] lg;
    logic [3:0] lk;
    logic       lk_nz;
    logic [1:0] mc;
    logic       mc_zero, mc_full, cyc_to;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur;
  logic kc, pc, pr, przerw, zerstan, lk_nz, mc_zero, mc_full, cyc_to;
  logic [2:0] lg;
  logic [3:0] lk;
  logic [1:0] mc;

  pm_seq #(.LG_W(3), .LK_W(4), .MC_W(2), .KC_LEN(KC_LEN), .PC_LEN(PC_LEN),
           .TO_CYCLES(TO_CYC)) dut (
    .clk(clk), .clm(cur.clm), .ekc(cur.ekc), .got(cur.got),
    .fetch_req(cur.fetch), .irq_req(cur.irq),
    .kc(kc), .pc(pc), .pr(pr), .przerw(przerw), .zerstan(zerstan),
    .lg_ld(cur.lg_ld), .lg_d(cur.lg_d), .lg_inc(cur.lg_inc), .lg(lg),
    .lk_ld(cur.lk_ld), .lk_d(cur.lk_d), .lk_dec(cur.lk_dec), .lk(lk), .lk_nz(lk_nz),
    .mc_inc(cur.mc_inc), .mc_clr(cur.mc_clr), .mc(mc), .mc_zero(mc_zero),
    .mc_full(mc_full), .cyc_to(cyc_to)
  );

  obs_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a cycle is "armed" waiting for got, then a countdown of KC_LEN+PC_LEN clocks
  // where the top KC_LEN values are the kc window and the rest the pc window.
  bit m_armed = 0;
  int m_busy = 0;
  int m_arm_clks = 0;
  bit m_pr = 1, m_przerw = 0, m_to = 0;
  int m_lg = 0, m_lk = 0, m_mc = 0;

  task automatic apply(input stim_t s);
    obs_t e;
    bit   timeout;
    @(posedge clk);
    #1;
    cur = s;
    e.kc      = (m_busy > PC_LEN);
    e.pc      = (m_busy > 0) && (m_busy <= PC_LEN);
    e.pr      = m_pr;
    e.przerw  = m_przerw;
    e.zerstan = e.pc | s.clm;
    e.lg      = 3'(m_lg);
    e.lk      = 4'(m_lk);
    e.lk_nz   = (m_lk != 0);
    e.mc      = 2'(m_mc);
    e.mc_zero = (m_mc == 0);
    e.mc_full = (m_mc == 3);
    e.cyc_to  = m_to;
    exp_q.push_back(e);
    if (s.clm) begin
      m_armed = 0; m_busy = 0; m_lg = 0; m_lk = 0; m_mc = 0;
      m_pr = 1; m_przerw = 0; m_to = 0;
    end else begin
      if (e.pc) begin
        m_lg = 0; m_lk = 0;
      end else begin
        if (s.lg_ld) m_lg = s.lg_d;
        else if (s.lg_inc) m_lg = (m_lg + 1) % 8;
        if (s.lk_ld) m_lk = s.lk_d;
        else if (s.lk_dec && m_lk > 0) m_lk = m_lk - 1;
      end
      if (s.mc_clr) m_mc = 0;
      else if (s.mc_inc && m_mc < 3) m_mc = m_mc + 1;
      if (m_busy > 0) begin
        if (m_busy == PC_LEN + 1) begin
          m_przerw = s.irq;
          m_pr     = !s.irq && s.fetch;
        end
        m_busy--;
      end else if (m_armed) begin
        m_arm_clks++;
        timeout = 0;
`ifdef PM_CYC_TO_EN
        timeout = !s.got && (m_arm_clks == TO_CYC);
        if (timeout) m_to = 1;
`endif
        if (s.got || timeout) begin
          m_armed = 0;
          m_busy  = KC_LEN + PC_LEN;
        end
      end else if (s.ekc) begin
        m_armed    = 1;
        m_arm_clks = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {kc, pc, pr, przerw, zerstan, lg, lk, lk_nz, mc, mc_zero, mc_full, cyc_to};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%h expected=%h (kc,pc,pr,przerw,zerstan,lg,lk,lk_nz,mc,mc_zero,mc_full,cyc_to)",
                 cyc, a, e);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    stim_t s;
    cur = '0;
    cur.clm = 1'b1;
    repeat (2) @(posedge clk);

    s = '0; s.clm = 1; apply(s);

    // Full cycle with interrupt request; lg_ld held through the pc pulse.
    s = '0; s.ekc = 1; s.irq = 1; apply(s);
    s.ekc = 0; apply(s); apply(s);
    s.got = 1; apply(s);
    s.got = 0; s.lg_ld = 1; s.lg_d = 3'h5;
    repeat (4) apply(s);

    // Step counter load, decrement to zero and hold, load beats dec.
    s = '0; s.lk_ld = 1; s.lk_d = 4'h3; apply(s);
    s.lk_ld = 0; s.lk_dec = 1; repeat (4) apply(s);
    s.lk_ld = 1; s.lk_d = 4'h9; apply(s);
    s = '0; apply(s);

    // Group counter wrap.
    s = '0; s.lg_ld = 1; s.lg_d = 3'h7; apply(s);
    s.lg_ld = 0; s.lg_inc = 1; repeat (2) apply(s);

    // Premodification saturation and clear priority.
    s = '0; s.mc_inc = 1; repeat (4) apply(s);
    s.mc_clr = 1; apply(s);
    s = '0; apply(s);

    // Abort during KC.
    s = '0; s.ekc = 1; apply(s);
    s = '0; s.got = 1; apply(s);
    s = '0; s.fetch = 0; apply(s);
    s.clm = 1; apply(s);
    s.clm = 0; repeat (4) apply(s);

`ifdef PM_CYC_TO_EN
    s = '0; s.ekc = 1; s.fetch = 1; apply(s);
    s.ekc = 0; repeat (TO_CYC + 5) apply(s);
    s.clm = 1; apply(s);
`endif

    for (int i = 0; i < 1500; i++) begin
      s = '0;
      s.clm    = ($urandom_range(0, 59) == 0);
      s.ekc    = ($urandom_range(0, 2) == 0);
      s.got    = ($urandom_range(0, 2) == 0);
      s.fetch  = $urandom_range(0, 1) == 1;
      s.irq    = ($urandom_range(0, 3) == 0);
      s.lg_ld  = ($urandom_range(0, 7) == 0);
      s.lg_d   = 3'($urandom);
      s.lg_inc = $urandom_range(0, 1) == 1;
      s.lk_ld  = ($urandom_range(0, 5) == 0);
      s.lk_d   = 4'($urandom);
      s.lk_dec = $urandom_range(0, 1) == 1;
      s.mc_inc = ($urandom_range(0, 2) == 0);
      s.mc_clr = ($urandom_range(0, 9) == 0);
      apply(s);
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
